// File: rtl/proc_pkg.sv
// Shared encodings for the processor state bus and datapath control fields.
// Also holds the terminal-state predicate used by the control unit.
package proc_pkg;

    localparam int STATE_W = 6;

    localparam logic [STATE_W-1:0] S_IDLE   = 6'd0;
    localparam logic [STATE_W-1:0] S_FETCH1 = 6'd1;
    localparam logic [STATE_W-1:0] S_FETCH2 = 6'd2;
    localparam logic [STATE_W-1:0] S_FETCH3 = 6'd3;
    localparam logic [STATE_W-1:0] S_CLAC   = 6'd4;
    localparam logic [STATE_W-1:0] S_LDAC1  = 6'd5;
    localparam logic [STATE_W-1:0] S_LDAC2  = 6'd6;
    localparam logic [STATE_W-1:0] S_LDAC3  = 6'd7;
    localparam logic [STATE_W-1:0] S_LDAC4  = 6'd8;
    localparam logic [STATE_W-1:0] S_STAC1  = 6'd9;
    localparam logic [STATE_W-1:0] S_STAC2  = 6'd10;
    localparam logic [STATE_W-1:0] S_STAC3  = 6'd11;
    localparam logic [STATE_W-1:0] S_STAC4  = 6'd12;
    localparam logic [STATE_W-1:0] S_MVACR  = 6'd13;
    localparam logic [STATE_W-1:0] S_MVRAC  = 6'd14;
    localparam logic [STATE_W-1:0] S_ADD    = 6'd15;
    localparam logic [STATE_W-1:0] S_MUL    = 6'd16;

    localparam logic [1:0] BUS_PC = 2'd0;
    localparam logic [1:0] BUS_DR = 2'd1;
    localparam logic [1:0] BUS_AC = 2'd2;
    localparam logic [1:0] BUS_R  = 2'd3;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_MUL  = 2'd2;

    typedef struct packed {
        logic       ar_ld;
        logic       dr_ld;
        logic       ir_ld;
        logic       r_ld;
        logic       ac_ld;
        logic       ac_clr;
        logic       pc_inc;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] bus_sel;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_terminal(input logic [STATE_W-1:0] s);
        return (s == S_CLAC)  || (s == S_LDAC4) || (s == S_STAC4) ||
               (s == S_MVACR) || (s == S_MVRAC) || (s == S_ADD)   ||
               (s == S_MUL);
    endfunction

endpackage

// File: rtl/cu_transition_check.sv
// Combinational legality check of one state-bus step (prev_state -> state).
// complete marks a legal return to idle from a terminal state.
module cu_transition_check
    import proc_pkg::*;
(
    input  logic [STATE_W-1:0] prev_state,
    input  logic [STATE_W-1:0] state,
    output logic               legal,
    output logic               complete
);

    always_comb begin
        legal = 1'b0;
        case (prev_state)
            S_IDLE:   legal = (state == S_IDLE) || (state == S_FETCH1);
            S_FETCH1: legal = (state == S_FETCH2);
            S_FETCH2: legal = (state == S_FETCH3);
            S_FETCH3: legal = (state == S_IDLE)  || (state == S_CLAC)  ||
                              (state == S_LDAC1) || (state == S_STAC1) ||
                              (state == S_MVACR) || (state == S_MVRAC) ||
                              (state == S_ADD)   || (state == S_MUL);
            S_LDAC1, S_LDAC2, S_LDAC3,
            S_STAC1, S_STAC2, S_STAC3:
                      legal = (state == prev_state + 6'd1);
            S_CLAC, S_LDAC4, S_STAC4, S_MVACR, S_MVRAC, S_ADD, S_MUL:
                      legal = (state == S_IDLE);
            default:  legal = 1'b0;
        endcase
    end

    assign complete = legal && is_terminal(prev_state) && (state == S_IDLE);

endmodule

// File: rtl/control_unit.sv
// Decodes the processor state bus into registered datapath strobes and
// tracks the state sequence for retire counting and error flagging.
module control_unit #(
    parameter int STATE_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] state,
    output logic               ar_ld,
    output logic               dr_ld,
    output logic               ir_ld,
    output logic               r_ld,
    output logic               ac_ld,
    output logic               ac_clr,
    output logic               pc_inc,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [1:0]         bus_sel,
    output logic [1:0]         alu_op,
    output logic               done,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic               err
);
    import proc_pkg::*;

    logic [1:0]         rst_sync_reg;
    logic               rst_int_n;
    ctrl_t              ctrl_next;
    ctrl_t              ctrl_reg;
    logic [STATE_W-1:0] prev_state_reg;
    logic               done_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               legal;
    logic               complete;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) rst_sync_reg <= 2'b00;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_int_n = rst_sync_reg[1];

    always_comb begin
        ctrl_next = '0;
        case (state)
            S_FETCH1:         begin ctrl_next.ar_ld = 1'b1; ctrl_next.bus_sel = BUS_PC; end
            S_FETCH2, S_LDAC1, S_STAC1: begin
                ctrl_next.mem_rd = 1'b1;
                ctrl_next.dr_ld  = 1'b1;
                ctrl_next.pc_inc = 1'b1;
            end
            S_FETCH3:         begin ctrl_next.ir_ld = 1'b1; ctrl_next.bus_sel = BUS_DR; end
            S_CLAC:           ctrl_next.ac_clr = 1'b1;
            S_LDAC2, S_STAC2: begin ctrl_next.ar_ld = 1'b1; ctrl_next.bus_sel = BUS_DR; end
            S_LDAC3:          begin ctrl_next.mem_rd = 1'b1; ctrl_next.dr_ld = 1'b1; end
            S_LDAC4: begin
                ctrl_next.ac_ld   = 1'b1;
                ctrl_next.bus_sel = BUS_DR;
                ctrl_next.alu_op  = ALU_PASS;
            end
            S_STAC3:          begin ctrl_next.dr_ld = 1'b1; ctrl_next.bus_sel = BUS_AC; end
            S_STAC4:          ctrl_next.mem_wr = 1'b1;
            S_MVACR:          begin ctrl_next.r_ld = 1'b1; ctrl_next.bus_sel = BUS_AC; end
            S_MVRAC: begin
                ctrl_next.ac_ld   = 1'b1;
                ctrl_next.bus_sel = BUS_R;
                ctrl_next.alu_op  = ALU_PASS;
            end
            S_ADD:            begin ctrl_next.ac_ld = 1'b1; ctrl_next.alu_op = ALU_ADD; end
            S_MUL:            begin ctrl_next.ac_ld = 1'b1; ctrl_next.alu_op = ALU_MUL; end
            default:          ctrl_next = '0;
        endcase
    end

    cu_transition_check u_check (
        .prev_state (prev_state_reg),
        .state      (state),
        .legal      (legal),
        .complete   (complete)
    );

    // Illegal codes never form a legal pair, so !legal also covers them.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ctrl_reg       <= '0;
            prev_state_reg <= S_IDLE;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            ctrl_reg       <= ctrl_next;
            prev_state_reg <= state;
            done_reg       <= complete;
            if (!legal)   err_reg <= 1'b1;
            if (complete) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign ar_ld     = ctrl_reg.ar_ld;
    assign dr_ld     = ctrl_reg.dr_ld;
    assign ir_ld     = ctrl_reg.ir_ld;
    assign r_ld      = ctrl_reg.r_ld;
    assign ac_ld     = ctrl_reg.ac_ld;
    assign ac_clr    = ctrl_reg.ac_clr;
    assign pc_inc    = ctrl_reg.pc_inc;
    assign mem_rd    = ctrl_reg.mem_rd;
    assign mem_wr    = ctrl_reg.mem_wr;
    assign bus_sel   = ctrl_reg.bus_sel;
    assign alu_op    = ctrl_reg.alu_op;
    assign done      = done_reg;
    assign instr_cnt = cnt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues the expected response
// for each presented state; a monitor compares one cycle later.
module tb_control_unit;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             rst_n = 1'b1;
    logic [5:0]       state = 6'd0;
    logic             ar_ld, dr_ld, ir_ld, r_ld, ac_ld, ac_clr, pc_inc;
    logic             mem_rd, mem_wr, done, err;
    logic [1:0]       bus_sel, alu_op;
    logic [CNT_W-1:0] instr_cnt;

    control_unit #(.STATE_W(6), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .state     (state),
        .ar_ld     (ar_ld),
        .dr_ld     (dr_ld),
        .ir_ld     (ir_ld),
        .r_ld      (r_ld),
        .ac_ld     (ac_ld),
        .ac_clr    (ac_clr),
        .pc_inc    (pc_inc),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .bus_sel   (bus_sel),
        .alu_op    (alu_op),
        .done      (done),
        .instr_cnt (instr_cnt),
        .err       (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int               due;
        int               sv;
        logic [12:0]      ctrl;
        logic             done;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycle_cnt = 0;

    wire [12:0] dut_ctrl = {ar_ld, dr_ld, ir_ld, r_ld, ac_ld, ac_clr, pc_inc,
                            mem_rd, mem_wr, bus_sel, alu_op};

    function automatic logic [12:0] mk(input bit ar, dr, ir, r, ac, clr, inc, rd, wr,
                                       input logic [1:0] bus, alu);
        return {ar, dr, ir, r, ac, clr, inc, rd, wr, bus, alu};
    endfunction

    // Expected strobes for a state code, written from the decode table.
    function automatic logic [12:0] model(input int s);
        case (s)
            1:      return mk(1,0,0,0,0,0,0,0,0, 2'd0, 2'd0);
            2, 5, 9:return mk(0,1,0,0,0,0,1,1,0, 2'd0, 2'd0);
            3:      return mk(0,0,1,0,0,0,0,0,0, 2'd1, 2'd0);
            4:      return mk(0,0,0,0,0,1,0,0,0, 2'd0, 2'd0);
            6, 10:  return mk(1,0,0,0,0,0,0,0,0, 2'd1, 2'd0);
            7:      return mk(0,1,0,0,0,0,0,1,0, 2'd0, 2'd0);
            8:      return mk(0,0,0,0,1,0,0,0,0, 2'd1, 2'd0);
            11:     return mk(0,1,0,0,0,0,0,0,0, 2'd2, 2'd0);
            12:     return mk(0,0,0,0,0,0,0,0,1, 2'd0, 2'd0);
            13:     return mk(0,0,0,1,0,0,0,0,0, 2'd2, 2'd0);
            14:     return mk(0,0,0,0,1,0,0,0,0, 2'd3, 2'd0);
            15:     return mk(0,0,0,0,1,0,0,0,0, 2'd0, 2'd1);
            16:     return mk(0,0,0,0,1,0,0,0,0, 2'd0, 2'd2);
            default:return 13'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input int sv, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s state=%0d got=%0h want=%0h", nm, sv, act, want);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cycle_cnt++;
    end

    // Monitor: pops every expectation whose response cycle has arrived.
    initial forever begin
        @(negedge clock);
        while (sb.size() > 0 && sb[0].due <= cycle_cnt) begin
            mon_e = sb.pop_front();
            if (mon_e.due < cycle_cnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale state=%0d got=cycle%0d want=cycle%0d",
                         mon_e.sv, cycle_cnt, mon_e.due);
            end else begin
                chk("ctrl",      mon_e.sv, 32'(dut_ctrl),  32'(mon_e.ctrl));
                chk("done",      mon_e.sv, 32'(done),      32'(mon_e.done));
                chk("err",       mon_e.sv, 32'(err),       32'(mon_e.err));
                chk("instr_cnt", mon_e.sv, 32'(instr_cnt), 32'(mon_e.cnt));
                $display("txn cyc=%0d state=%0d ctrl=%h done=%b err=%b cnt=%0d",
                         cycle_cnt, mon_e.sv, dut_ctrl, done, err, instr_cnt);
            end
        end
    end

    task automatic step(input int s, input bit d, input bit e, input int c);
        exp_t x;
        @(posedge clock);
        #1;
        state  = 6'(s);
        x.due  = cycle_cnt + 1;
        x.sv   = s;
        x.ctrl = model(s);
        x.done = d;
        x.err  = e;
        x.cnt  = CNT_W'(c);
        sb.push_back(x);
    endtask

    task automatic flush();
        int k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(negedge clock);
            #2;
            k++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL flush got=%0d pending want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_ctrl"}, int'(state), 32'(dut_ctrl),  32'd0);
        chk({nm, "_done"}, int'(state), 32'(done),      32'd0);
        chk({nm, "_err"},  int'(state), 32'(err),       32'd0);
        chk({nm, "_cnt"},  int'(state), 32'(instr_cnt), 32'd0);
    endtask

    task automatic do_reset(input int resume_state);
        flush();
        rst_n = 1'b0;
        #1;
        check_cleared("reset");
        state = 6'(resume_state);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    initial begin
        #2;
        do_reset(0);

        // ldac: 0,1,2,3,5,6,7,8,0
        step(0, 0, 0, 0);
        step(1, 0, 0, 0); step(2, 0, 0, 0); step(3, 0, 0, 0);
        step(5, 0, 0, 0); step(6, 0, 0, 0); step(7, 0, 0, 0); step(8, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);

        // stac then add
        do_reset(0);
        step(1, 0, 0, 0); step(2, 0, 0, 0); step(3, 0, 0, 0);
        step(9, 0, 0, 0); step(10, 0, 0, 0); step(11, 0, 0, 0); step(12, 0, 0, 0);
        step(0, 1, 0, 1);
        step(1, 0, 0, 1); step(2, 0, 0, 1); step(3, 0, 0, 1); step(15, 0, 0, 1);
        step(0, 1, 0, 2);
        step(0, 0, 0, 2);

        // halt: fetch then straight back to idle is not a completion
        step(1, 0, 0, 2); step(2, 0, 0, 2); step(3, 0, 0, 2);
        step(0, 0, 0, 2);
        step(0, 0, 0, 2);

        // mvacr, mvrac, mul decode
        step(1, 0, 0, 2); step(2, 0, 0, 2); step(3, 0, 0, 2); step(13, 0, 0, 2);
        step(0, 1, 0, 3);
        step(1, 0, 0, 3); step(2, 0, 0, 3); step(3, 0, 0, 3); step(14, 0, 0, 3);
        step(0, 1, 0, 4);
        step(1, 0, 0, 4); step(2, 0, 0, 4); step(3, 0, 0, 4); step(16, 0, 0, 4);
        step(0, 1, 0, 5);

        // illegal code 20, error stays through a later clac
        do_reset(0);
        step(0, 0, 0, 0);
        step(20, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0); step(2, 0, 1, 0); step(3, 0, 1, 0); step(4, 0, 1, 0);
        step(0, 1, 1, 1);

        // skipped fetch2
        do_reset(0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(3, 0, 1, 0);

        // non-idle hold is illegal
        do_reset(0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);

        // counter wrap at CNT_W = 4
        do_reset(0);
        for (int k = 1; k <= 16; k++) begin
            step(1, 0, 0, k - 1); step(2, 0, 0, k - 1);
            step(3, 0, 0, k - 1); step(4, 0, 0, k - 1);
            step(0, 1, 0, k % 16);
        end

        // reset in the middle of ldac2, then resume mid-instruction
        do_reset(0);
        step(1, 0, 0, 0); step(2, 0, 0, 0); step(3, 0, 0, 0);
        step(5, 0, 0, 0); step(6, 0, 0, 0);
        flush();
        chk("ldac2_ar_ld", 6, 32'(ar_ld), 32'd1);
        rst_n = 1'b0;
        #1;
        check_cleared("mid_reset");
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(posedge clock);
        step(7, 0, 1, 0);
        step(8, 0, 1, 0);

        flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
